fetch_stage: RTL and testbench

//  Consumer end of the PC-generation interface. Takes the current PC from the PC-gen stage and

---
 rtl/mmm_pkg.sv | 12 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmm_pkg.sv
// Shared widths and the instruction-queue entry type for the fetch stage.
package mmm_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with wrap-bit pointers, occupancy count and a synchronous clear.
module sync_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [31:0]
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       push,
   input  T                           push_data,
   input  logic                       pop,
   output T                           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   T             mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign count    = wr_ptr - rd_ptr;
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (count == (AW+1)'(DEPTH));
   assign pop_data = mem[rd_ptr[AW-1:0]];

   // A push into a full buffer is only legal when the head leaves in the same cycle.
   assign do_push  = push && (!full || pop);
   assign do_pop   = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: issues PC-gen's PC to instruction memory, pairs in-order responses with their
// PCs and queues {pc,instr} for decode; drops in-flight work on a mispredict flush.
module fetch_stage
   import mmm_pkg::*;
#(
   parameter int IQ_DEPTH  = 4,
   parameter int MAX_OUTST = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            fetch_ready_o,
   input  logic            flush_i,
   output logic            imem_req_valid_o,
   input  logic            imem_req_ready_i,
   output logic [XLEN-1:0] imem_req_addr_o,
   input  logic            imem_resp_valid_i,
   input  logic [ILEN-1:0] imem_resp_instr_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [ILEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o
);

   // Handshakes: a transfer happens on a cycle where valid && ready; valid never depends on
   // ready, and the producer holds its data stable until the transfer completes.

   localparam int CW         = $clog2(MAX_OUTST + 1);
   localparam int PEND_DEPTH = (MAX_OUTST < 2) ? 2 : MAX_OUTST;

   logic [CW-1:0]                   outst_cnt;
   logic [CW-1:0]                   discard_cnt;
   logic                            req_fire;
   logic                            resp_keep;
   logic                            iq_push;
   logic                            iq_pop;
   fetch_entry_t                    iq_in;
   fetch_entry_t                    iq_head;
   logic                            iq_full;
   logic                            iq_empty;
   logic [$clog2(IQ_DEPTH):0]       iq_cnt;
   logic [XLEN-1:0]                 pend_pc;
   logic                            pend_full;
   logic                            pend_empty;
   logic [$clog2(PEND_DEPTH):0]     pend_cnt;

   // Credit rule: every issued request already owns an IQ slot, so responses never stall.
   assign imem_req_valid_o = !rst_i && !flush_i
                             && (int'(outst_cnt) < MAX_OUTST)
                             && (int'(outst_cnt) + int'(iq_cnt) < IQ_DEPTH);
   assign imem_req_addr_o  = pc_i;
   assign req_fire         = imem_req_valid_o && imem_req_ready_i;
   assign fetch_ready_o    = req_fire;

   assign resp_keep = imem_resp_valid_i && (discard_cnt == '0) && !flush_i;
   assign iq_push   = resp_keep;
   assign iq_pop    = instr_valid_o && instr_ready_i && !flush_i;
   assign iq_in     = '{pc: pend_pc, instr: imem_resp_instr_i};

   assign instr_valid_o = !iq_empty;
   assign instr_o       = iq_head.instr;
   assign instr_pc_o    = iq_head.pc;

   sync_fifo #(.DEPTH(PEND_DEPTH), .T(logic [XLEN-1:0])) u_pend_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .clear     (flush_i),
      .push      (req_fire),
      .push_data (pc_i),
      .pop       (resp_keep),
      .pop_data  (pend_pc),
      .full      (pend_full),
      .empty     (pend_empty),
      .count     (pend_cnt)
   );

   sync_fifo #(.DEPTH(IQ_DEPTH), .T(fetch_entry_t)) u_iq_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .clear     (flush_i),
      .push      (iq_push),
      .push_data (iq_in),
      .pop       (iq_pop),
      .pop_data  (iq_head),
      .full      (iq_full),
      .empty     (iq_empty),
      .count     (iq_cnt)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         outst_cnt   <= '0;
         discard_cnt <= '0;
      end else begin
         case ({req_fire, imem_resp_valid_i})
            2'b10:   outst_cnt <= outst_cnt + 1'b1;
            2'b01:   if (outst_cnt != '0) outst_cnt <= outst_cnt - 1'b1;
            default: outst_cnt <= outst_cnt;
         endcase
         // Everything still in flight at the flush belongs to the wrong path.
         if (flush_i)
            discard_cnt <= outst_cnt - CW'(imem_resp_valid_i && (outst_cnt != '0));
         else if (imem_resp_valid_i && (discard_cnt != '0))
            discard_cnt <= discard_cnt - 1'b1;
      end
   end

   a_credit : assert property (@(posedge clk_i) disable iff (rst_i)
      int'(outst_cnt) + int'(iq_cnt) <= IQ_DEPTH);
   a_track  : assert property (@(posedge clk_i) disable iff (rst_i)
      int'(outst_cnt) == int'(pend_cnt) + int'(discard_cnt));
   a_pend   : assert property (@(posedge clk_i) disable iff (rst_i)
      (resp_keep |-> !pend_empty) and (req_fire |-> !pend_full));
   a_iq     : assert property (@(posedge clk_i) disable iff (rst_i)
      iq_push |-> (!iq_full || iq_pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: an in-order memory model tagged with flush epochs predicts
// every request handshake and every entry decode should see.
module tb_fetch_stage;
   import mmm_pkg::*;

   localparam int IQ_DEPTH  = 4;
   localparam int MAX_OUTST = 2;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic [XLEN-1:0] pc_i = '0;
   logic            fetch_ready_o;
   logic            flush_i = 1'b0;
   logic            imem_req_valid_o;
   logic            imem_req_ready_i = 1'b0;
   logic [XLEN-1:0] imem_req_addr_o;
   logic            imem_resp_valid_i = 1'b0;
   logic [ILEN-1:0] imem_resp_instr_i = '0;
   logic            instr_valid_o;
   logic            instr_ready_i = 1'b0;
   logic [ILEN-1:0] instr_o;
   logic [XLEN-1:0] instr_pc_o;

   fetch_stage #(.IQ_DEPTH(IQ_DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .pc_i              (pc_i),
      .fetch_ready_o     (fetch_ready_o),
      .flush_i           (flush_i),
      .imem_req_valid_o  (imem_req_valid_o),
      .imem_req_ready_i  (imem_req_ready_i),
      .imem_req_addr_o   (imem_req_addr_o),
      .imem_resp_valid_i (imem_resp_valid_i),
      .imem_resp_instr_i (imem_resp_instr_i),
      .instr_valid_o     (instr_valid_o),
      .instr_ready_i     (instr_ready_i),
      .instr_o           (instr_o),
      .instr_pc_o        (instr_pc_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [XLEN-1:0] pc;
      int              due;
      int              epoch;
   } mreq_t;

   mreq_t           mem_q[$];
   fetch_entry_t    iq_q[$];
   logic [XLEN-1:0] dec_log[$];
   int              cyc, epoch, n_acc, n_checks, n_pass;
   int              rdy_pct, dec_pct, lat_min, lat_max;
   bit              flush_next;
   logic [XLEN-1:0] cur_pc, redirect_pc;

   function automatic logic [ILEN-1:0] instr_of(input logic [XLEN-1:0] pc);
      return (pc * 32'd3) ^ 32'h1357_9bdf;
   endfunction

   // One clock of traffic: drive at the falling edge, compare 1 time unit later, advance model.
   task automatic do_cycle();
      bit           resp, exp_rv, exp_fr, pop;
      mreq_t        head, nreq;
      fetch_entry_t ent;
      resp              = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      flush_i           = flush_next;
      flush_next        = 1'b0;
      pc_i              = cur_pc;
      imem_req_ready_i  = ($urandom_range(0, 99) < rdy_pct);
      instr_ready_i     = ($urandom_range(0, 99) < dec_pct);
      imem_resp_valid_i = resp;
      imem_resp_instr_i = resp ? instr_of(mem_q[0].pc) : $urandom();
      #1;
      exp_rv = !flush_i && (mem_q.size() < MAX_OUTST) && (mem_q.size() + iq_q.size() < IQ_DEPTH);
      exp_fr = exp_rv && imem_req_ready_i;
      n_checks++;
      if (imem_req_valid_o !== exp_rv)
         $display("FAIL req_valid cyc=%0d got=%b want=%b", cyc, imem_req_valid_o, exp_rv);
      else n_pass++;
      n_checks++;
      if (fetch_ready_o !== exp_fr)
         $display("FAIL fetch_ready cyc=%0d got=%b want=%b", cyc, fetch_ready_o, exp_fr);
      else n_pass++;
      n_checks++;
      if (imem_req_addr_o !== cur_pc)
         $display("FAIL req_addr cyc=%0d got=%h want=%h", cyc, imem_req_addr_o, cur_pc);
      else n_pass++;
      n_checks++;
      if (instr_valid_o !== (iq_q.size() > 0))
         $display("FAIL instr_valid cyc=%0d got=%b want=%b", cyc, instr_valid_o, iq_q.size() > 0);
      else n_pass++;
      if (iq_q.size() > 0) begin
         n_checks++;
         if (instr_pc_o !== iq_q[0].pc)
            $display("FAIL instr_pc cyc=%0d got=%h want=%h", cyc, instr_pc_o, iq_q[0].pc);
         else n_pass++;
         n_checks++;
         if (instr_o !== iq_q[0].instr)
            $display("FAIL instr cyc=%0d got=%h want=%h", cyc, instr_o, iq_q[0].instr);
         else n_pass++;
      end
      pop = !flush_i && (iq_q.size() > 0) && instr_ready_i;
      if (pop) begin
         dec_log.push_back(iq_q[0].pc);
         void'(iq_q.pop_front());
      end
      if (resp) begin
         head = mem_q.pop_front();
         if (!flush_i && head.epoch == epoch) begin
            ent.pc    = head.pc;
            ent.instr = instr_of(head.pc);
            iq_q.push_back(ent);
         end
      end
      if (flush_i) begin
         iq_q.delete();
         dec_log.delete();
         epoch++;
         cur_pc = redirect_pc;
      end
      if (exp_fr) begin
         nreq.pc    = cur_pc;
         nreq.due   = cyc + int'($urandom_range(lat_min, lat_max));
         nreq.epoch = epoch;
         mem_q.push_back(nreq);
         n_acc++;
         cur_pc += 4;
      end
      @(posedge clk_i);
      @(negedge clk_i);
      cyc++;
   endtask

   // Reset held two cycles with the memory side ready, so a leaking request would show.
   task automatic reset_dut();
      rst_i             = 1'b1;
      flush_i           = 1'b0;
      imem_req_ready_i  = 1'b1;
      imem_resp_valid_i = 1'b0;
      instr_ready_i     = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (instr_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0 || fetch_ready_o !== 1'b0)
            $display("FAIL reset_valids got iv=%b rv=%b fr=%b want 0", instr_valid_o,
                     imem_req_valid_o, fetch_ready_o);
         else n_pass++;
         n_checks++;
         if (instr_o !== '0 || instr_pc_o !== '0)
            $display("FAIL reset_data got instr=%h pc=%h want 0", instr_o, instr_pc_o);
         else n_pass++;
         @(negedge clk_i);
      end
      rst_i = 1'b0;
      mem_q.delete();
      iq_q.delete();
      dec_log.delete();
      epoch++;
      cur_pc     = '0;
      flush_next = 1'b0;
      n_acc      = 0;
   endtask

   task automatic test_reset();
      reset_dut();
      rdy_pct = 80; dec_pct = 50; lat_min = 1; lat_max = 4;
      repeat (20) do_cycle();
      reset_dut();
   endtask

   task automatic test_stream();
      reset_dut();
      rdy_pct = 100; dec_pct = 100; lat_min = 1; lat_max = 1;
      repeat (3) do_cycle();
      n_checks++;
      if (dec_log.size() != 1)
         $display("FAIL stream_latency got=%0d pops want=1", dec_log.size());
      else n_pass++;
      repeat (5) do_cycle();
      n_checks++;
      if (dec_log.size() < 3 || dec_log[0] !== 32'h0 || dec_log[1] !== 32'h4 || dec_log[2] !== 32'h8)
         $display("FAIL stream_order got n=%0d first=%h want 0,4,8", dec_log.size(),
                  (dec_log.size() > 0) ? dec_log[0] : 32'hx);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      reset_dut();
      rdy_pct = 100; dec_pct = 0; lat_min = 1; lat_max = 1;
      repeat (10) do_cycle();
      n_checks++;
      if (n_acc != IQ_DEPTH || imem_req_valid_o !== 1'b0)
         $display("FAIL bp_fill got acc=%0d rv=%b want acc=%0d rv=0", n_acc, imem_req_valid_o, IQ_DEPTH);
      else n_pass++;
      dec_pct = 100;
      do_cycle();
      dec_pct = 0;
      repeat (5) do_cycle();
      n_checks++;
      if (n_acc != IQ_DEPTH + 1)
         $display("FAIL bp_refill got acc=%0d want=%0d", n_acc, IQ_DEPTH + 1);
      else n_pass++;
   endtask

   task automatic test_outst_cap();
      reset_dut();
      rdy_pct = 100; dec_pct = 100; lat_min = 5; lat_max = 5;
      repeat (6) do_cycle();
      n_checks++;
      if (n_acc != MAX_OUTST)
         $display("FAIL outst_cap got acc=%0d want=%0d", n_acc, MAX_OUTST);
      else n_pass++;
      do_cycle();
      n_checks++;
      if (n_acc != MAX_OUTST + 1)
         $display("FAIL outst_release got acc=%0d want=%0d", n_acc, MAX_OUTST + 1);
      else n_pass++;
   endtask

   task automatic test_flush();
      reset_dut();
      rdy_pct = 100; dec_pct = 100; lat_min = 4; lat_max = 4;
      redirect_pc = 32'h100;
      repeat (2) do_cycle();
      flush_next = 1'b1;
      do_cycle();
      n_checks++;
      if (instr_valid_o !== 1'b0)
         $display("FAIL flush_iq_empty got=%b want=0", instr_valid_o);
      else n_pass++;
      lat_min = 1; lat_max = 1;
      repeat (10) do_cycle();
      n_checks++;
      if (dec_log.size() == 0 || dec_log[0] !== 32'h100)
         $display("FAIL flush_redirect got n=%0d first=%h want 100", dec_log.size(),
                  (dec_log.size() > 0) ? dec_log[0] : 32'hx);
      else n_pass++;
   endtask

   task automatic test_flush_coincident();
      bit found = 1'b0;
      reset_dut();
      rdy_pct = 100; dec_pct = 100; lat_min = 2; lat_max = 2;
      redirect_pc = 32'h200;
      for (int k = 0; k < 20 && !found; k++) begin
         if (k > 3 && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            flush_next = 1'b1;
            found      = 1'b1;
         end
         do_cycle();
      end
      n_checks++;
      if (!found) $display("FAIL coincide_setup got=0 want=1");
      else n_pass++;
      repeat (10) do_cycle();
      n_checks++;
      if (dec_log.size() == 0 || dec_log[0] !== 32'h200)
         $display("FAIL coincide_redirect got n=%0d first=%h want 200", dec_log.size(),
                  (dec_log.size() > 0) ? dec_log[0] : 32'hx);
      else n_pass++;
   endtask

   task automatic test_random();
      reset_dut();
      rdy_pct = 70; dec_pct = 60; lat_min = 1; lat_max = 6;
      for (int k = 0; k < 3000; k++) begin
         flush_next  = ($urandom_range(0, 99) < 4);
         redirect_pc = 32'h1000 + 32'($urandom_range(0, 255)) * 32'd4;
         do_cycle();
      end
   endtask

   initial begin
      cyc = 0; epoch = 0; n_acc = 0; n_checks = 0; n_pass = 0;
      rdy_pct = 0; dec_pct = 0; lat_min = 1; lat_max = 1;
      flush_next = 1'b0; cur_pc = '0; redirect_pc = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_outst_cap();
      test_flush();
      test_flush_coincident();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
